// File: rtl/display_mux_bcd.sv
// Multi-digit seven-segment driver: serial binary-to-BCD conversion feeding a time-multiplexed digit scanner.
// Latency: WIDTH cycles from load to display update; seg/an are registered, one cycle behind the scan index.
// Backpressure: none; load is accepted only while busy=0 and is dropped otherwise (no queuing).
//
// Ports:
//   i_clk, i_rst         rising-edge clock, asynchronous active-high reset
//   i_load, i_value      start a conversion of i_value (ignored while o_busy=1)
//   i_blank_zeros        live control: blank leading zeros (digit 0 always shown)
//   o_busy               conversion in progress
//   o_overflow           last converted value exceeded 10^DIGITS-1 (digits show "-")
//   o_seg[6:0]           segments a..g (o_seg[6]=a), polarity per ACTIVE_LOW
//   o_an[DIGITS-1:0]     digit enables, o_an[0]=least significant, polarity per ACTIVE_LOW
module display_mux_bcd #(
  parameter int DIGITS     = 4,
  parameter int WIDTH      = 14,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_value,
  input  logic              i_blank_zeros,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [6:0]        o_seg,
  output logic [DIGITS-1:0] o_an
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_DISP = pow10(DIGITS) - 64'd1;

  // XOR masks: all ones when outputs are active-low, so "off" is the mask itself.
  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW != 0}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW != 0}};

  // Active-high segment patterns {a,b,c,d,e,f,g}; non-decimal nibbles blank.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_bcd, w_bcd_adj, w_bcd_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf_pend;
  logic [BW-1:0]     r_disp;
  logic              r_overflow;
  logic [SW-1:0]     r_scan_cnt;
  logic [IW-1:0]     r_idx;
  logic [6:0]        r_seg, w_seg_raw;
  logic [DIGITS-1:0] r_an, w_an_raw;
  logic              w_busy, w_capture, w_last, w_scan_tc, w_upper_zero;
  logic [3:0]        w_nib;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_load) w_state_nxt = S_CONV;
      S_CONV:  if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == S_CONV);
    w_capture = (r_state == S_IDLE) && i_load;
    w_last    = (r_state == S_CONV) && (r_cnt == CW'(WIDTH - 1));
  end

  // Shift-and-add-3: correct every nibble >= 5 before the shift so it carries as decimal.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
    // The top BCD bit falls off; overflow is detected separately at capture.
    w_bcd_nxt = {w_bcd_adj[BW-2:0], r_shift[WIDTH-1]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      r_overflow <= 1'b0;
    end else if (w_capture) begin
      r_shift    <= i_value;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= (64'(i_value) > MAX_DISP);
    end else if (w_busy) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // Display and overflow flag move together so no mixed frame is ever shown.
        r_disp     <= w_bcd_nxt;
        r_overflow <= r_ovf_pend;
      end
    end
  end

  // ---------------- digit scanner ----------------
  assign w_scan_tc = (r_scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (w_scan_tc) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    w_nib        = r_disp[r_idx*4 +: 4];
    w_upper_zero = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if ((d >= int'(r_idx)) && (r_disp[d*4 +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
  end

  always_comb begin
    if (r_overflow)                                         w_seg_raw = 7'b0000001;
    else if (i_blank_zeros && (r_idx != '0) && w_upper_zero) w_seg_raw = 7'b0000000;
    else                                                     w_seg_raw = seg7(w_nib);
    w_an_raw = DIGITS'(1) << r_idx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= w_seg_raw ^ SEG_OFF;
      r_an  <= w_an_raw ^ AN_OFF;
    end
  end

  assign o_busy     = w_busy;
  assign o_overflow = r_overflow;
  assign o_seg      = r_seg;
  assign o_an       = r_an;

endmodule

// File: tb/tb_display_mux_bcd.sv
// Testbench for display_mux_bcd: directed and random conversions checked against a decimal reference model.
module tb_display_mux_bcd;

  localparam int DIGITS   = 4;
  localparam int WIDTH    = 14;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_zeros = 1'b0;
  logic [13:0] value = '0;
  logic        busy, overflow;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the value currently displayed and its overflow flag.
  int mv   = 0;
  bit movf = 1'b0;

  // Active-high lit segment sets {a..g} for decimal digits 0..9.
  logic [6:0] PAT [10];

  display_mux_bcd #(
    .DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_value(value),
    .i_blank_zeros(blank_zeros), .o_busy(busy), .o_overflow(overflow),
    .o_seg(seg), .o_an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int i);
    int p10;
    p10 = 1;
    for (int k = 0; k < i; k++) p10 = p10 * 10;
    if (movf) return 7'b1111110;
    if (blank_zeros && i > 0 && mv < p10) return 7'b1111111;
    return ~PAT[(mv / p10) % 10];
  endfunction

  // Observe one full frame: exactly one digit enabled each cycle, segments match the model.
  task automatic check_frame(input string tag);
    bit seen [4];
    int idx, nseen;
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    check({tag, "_ovf"}, 32'(overflow), 32'(movf));
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      idx = -1;
      for (int k = 0; k < 4; k++) if (an[k] === 1'b0) idx = k;
      check({tag, "_an_onehot"}, 32'($countones(~an)), 32'd1);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg(idx)));
      end
      @(negedge clk);
    end
    nseen = 0;
    for (int k = 0; k < 4; k++) if (seen[k]) nseen++;
    check({tag, "_all_digits"}, 32'(nseen), 32'd4);
  endtask

  // Load v, measure busy length, optionally re-assert load on the final conversion edge.
  task automatic run_conv(input int v, input bit late);
    int cnt;
    load  = 1'b1;
    value = 14'(v);
    @(negedge clk);
    load  = 1'b0;
    value = 14'($urandom);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (late && cnt == WIDTH) begin
        load  = 1'b1;
        value = 14'd1111;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_len", 32'(cnt), 32'(WIDTH));
    mv   = v;
    movf = (v > 9999);
    @(negedge clk);
    check("busy_idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt, s, v;
    logic [3:0] prev;
    PAT[0] = 7'b1111110; PAT[1] = 7'b0110000; PAT[2] = 7'b1101101;
    PAT[3] = 7'b1111001; PAT[4] = 7'b0110011; PAT[5] = 7'b1011011;
    PAT[6] = 7'b1011111; PAT[7] = 7'b1110000; PAT[8] = 7'b1111111;
    PAT[9] = 7'b1111011;

    // Reset state
    @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_frame("init_0000");

    // 1234 unblanked
    run_conv(1234, 1'b0);
    check_frame("v1234");

    // Leading-zero blanking, and blank_zeros taking effect live
    blank_zeros = 1'b1;
    run_conv(7, 1'b0);
    check_frame("v7_blank");
    blank_zeros = 1'b0;
    @(negedge clk);
    check_frame("v7_noblank");
    blank_zeros = 1'b1;
    run_conv(0, 1'b0);
    check_frame("v0_blank");
    blank_zeros = 1'b0;

    // Overflow and recovery; load on the last conversion edge is ignored
    run_conv(12000, 1'b0);
    check_frame("v12000_ovf");
    run_conv(9999, 1'b1);
    check_frame("v9999");

    // Load during a conversion is dropped
    load  = 1'b1;
    value = 14'd1234;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load  = 1'b1;
    value = 14'd4321;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("ign_busy_rest", 32'(cnt), 32'd11);
    mv   = 1234;
    movf = 1'b0;
    @(negedge clk);
    check("ign_no_requeue", 32'(busy), 32'd0);
    check_frame("ign_1234");

    // Reset in the middle of a conversion, with overflow previously set
    run_conv(12000, 1'b0);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    load  = 1'b1;
    value = 14'd1234;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    mv   = 0;
    movf = 1'b0;
    @(negedge clk);
    check_frame("midrst_0000");

    // Scan sequence: align to a digit change, then each enable held SCAN_DIV cycles in order
    prev = an;
    cnt  = 0;
    @(negedge clk);
    while (an === prev && cnt < 8) begin
      cnt++;
      @(negedge clk);
    end
    check("scan_align", 32'(cnt < 8), 32'd1);
    s = 0;
    for (int k = 0; k < 4; k++) if (an[k] === 1'b0) s = k;
    for (int c = 0; c < 40; c++) begin
      check("scan_an", 32'(an), 32'(4'b1111 ^ (4'b0001 << ((s + c / SCAN_DIV) % DIGITS))));
      @(negedge clk);
    end

    // Random conversions
    for (int it = 0; it < 8; it++) begin
      v = (it % 2 == 1) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 99));
      blank_zeros = 1'($urandom_range(0, 1));
      run_conv(v, it == 3);
      check_frame("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux_bcd.md
# display_mux_bcd

Parametrised multi-digit seven-segment driver and successor to the single-digit combinational decoders. It accepts a binary value on a load strobe and converts it to BCD sequentially with shift-and-add-3 (one bit per clock). It then drives DIGITS common-enable seven-segment positions by time-multiplexed scanning. It adds leading-zero blanking, overflow indication and output polarity selection, and sits between the counter/datapath logic and the board display pins.

## Interface
- DIGITS, 4: number of display positions (1..8).
- WIDTH, 14: width of binary input value.
- SCAN_DIV, 50000: clock cycles each digit stays enabled (≥2).
- ACTIVE_LOW, 1: 1 means seg and an are active-low (board default); 0 means active-high.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  start conversion of value; sampled only when busy=0.
- value  input  WIDTH  unsigned binary value to display.
- blank_zeros  input  1  1 means suppress leading zeros (digit 0 never blanked).
- busy  output  1  conversion in progress.
- overflow  output  1  displayed value exceeded 10^DIGITS−1.
- seg  output  7  segments, seg[6]=a … seg[0]=g.
- an  output  DIGITS  digit enables, an[0]=least significant digit.

## Operation
- States: IDLE and CONV.
- IDLE with load=1:
  - capture value into shift register; clear BCD register (DIGITS*4 bits); clear bit counter.
  - latch ovf_pend = (value > 10^DIGITS−1).
  - enter CONV.
- CONV, each cycle:
  - every BCD nibble ≥5 gets +3 (combinational).
  - {bcd, shift} shifts left one bit; bits leaving the top of bcd are discarded.
  - bit counter increments.
- After the WIDTH-th shift:
  - copy bcd to display register and ovf_pend to overflow, atomically.
  - return to IDLE.
- load while busy=1 is ignored; no queuing.
- Display register and overflow hold until the next completed conversion.
- Scanner runs continuously, independent of conversion:
  - scan counter counts 0..SCAN_DIV−1.
  - on terminal count, digit index increments and wraps DIGITS−1→0.
- Digit output for current index i:
  - overflow=1: only segment g lit ("-") on every digit.
  - else blank (all segments off) if blank_zeros=1, i>0, and nibbles i..DIGITS−1 are all zero.
  - else decode nibble i. Lit sets: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg. Nibbles 10–15 are unreachable and decode to blank.
- an: exactly one bit (index i) asserted; all others deasserted.
- Polarity: ACTIVE_LOW=1 inverts both seg and an at the output register.

## Timing
- Reset (async), all forced:
  - state IDLE, busy=0, overflow=0, display register 0, scan counter 0, index 0.
  - seg all off, an all off (all ones when ACTIVE_LOW=1).
- seg and an are registered. From the first edge after reset release, they reflect index/display with 1-cycle latency.
- Conversion timing:
  - load sampled at edge T0; busy=1 after T0.
  - shifts occur at edges T1..TWIDTH; display/overflow update at TWIDTH and busy=0 after TWIDTH.
  - busy is high for exactly WIDTH cycles.
  - load asserted at the edge TWIDTH is ignored; earliest new capture is TWIDTH+1.
- The display changes on the seg/an register one cycle after the display register update, without scanner resync.
- Each digit is enabled for exactly SCAN_DIV cycles; a full frame takes DIGITS*SCAN_DIV cycles.
- value and blank_zeros:
  - value is only sampled at capture.
  - blank_zeros is live and takes effect on the next output register update.
- Reset mid-conversion aborts it; the display returns to 0 and overflow to 0.

## Test plan
Config: DIGITS=4, WIDTH=14, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset -> seg=7'b1111111, an=4'b1111, busy=0, overflow=0. After release, the first frame shows 0000 with blank_zeros=0.
- load value=1234 -> busy high exactly 14 cycles. Then:
  - an=1110 gives seg=1001100 ("4").
  - an=0111 gives seg=1001111 ("1").
  - digits 1 and 2 show "3" (0000110) and "2" (0010010).
- blank_zeros=1, value=7 -> digit 0 seg=0001111; digits 1–3 seg=1111111. Then value=0 -> digit 0 seg=0000001, others blank.
- value=12000 -> overflow=1; all four digits seg=1111110. Next, value=9999 -> overflow=0 and all digits show "9" (0000100).
- Pulse load with 4321 three cycles into a 1234 conversion -> ignored; result shows 1234. Reset asserted mid-conversion -> immediate reset outputs; display shows 0.
- Scan check over 40 cycles -> index sequence 0,1,2,3,0… with each an pattern held 4 cycles and never two digits enabled at once.
